// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - NUM_CH-way arbiter onto one shared synchronous memory port
// Priority channel with a starvation guard, round-robin for the rest, tagged read return.
module mem_port_arbiter #(
   parameter int DATAWIDTH  = 16,
   parameter int ADDRWIDTH  = 16,
   parameter int NUM_CH     = 4,
   parameter int PRIO_CH    = 0,
   parameter int PRIO_MAX   = 4,
   parameter int RD_LATENCY = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CH-1:0]             req,
   input  logic [NUM_CH-1:0]             we,
   input  logic [NUM_CH*ADDRWIDTH-1:0]   addr,
   input  logic [NUM_CH*DATAWIDTH-1:0]   wdata,
   output logic [NUM_CH-1:0]             gnt,
   output logic [NUM_CH-1:0]             rvalid,
   output logic [DATAWIDTH-1:0]          rdata,
   output logic                          mem_en,
   output logic                          mem_we,
   output logic [ADDRWIDTH-1:0]          mem_addr,
   output logic [DATAWIDTH-1:0]          mem_din,
   input  logic [DATAWIDTH-1:0]          mem_dout
);

   localparam int PTRW  = $clog2(NUM_CH);
   localparam int DEPTH = RD_LATENCY + 1;
   localparam logic [NUM_CH-1:0] PRIO_BIT = NUM_CH'(1) << PRIO_CH;

   logic [PTRW-1:0]      rr_ptr;
   logic [PTRW-1:0]      rr_next;
   logic [3:0]           prio_cnt;
   logic [NUM_CH-1:0]    tag_pipe [DEPTH];
   logic                 others_req;
   logic                 prio_ok;
   logic                 rr_hit;
   int                   rr_ch;
   logic                 xfer;
   logic                 xfer_prio;
   logic                 sel_we;
   logic [ADDRWIDTH-1:0] sel_addr;
   logic [DATAWIDTH-1:0] sel_wdata;

   function automatic logic [NUM_CH-1:0] onehot(input int c);
      return NUM_CH'(1) << c;
   endfunction

   function automatic int wrap(input int s);
      return (s >= NUM_CH) ? s - NUM_CH : s;
   endfunction

   // Successor of channel c in round-robin order, never landing on the priority channel.
   function automatic int next_ch(input int c);
      int n;
      n = wrap(c + 1);
      if (n == PRIO_CH) n = wrap(n + 1);
      return n;
   endfunction

   assign others_req = |(req & ~PRIO_BIT);
   assign prio_ok    = (|(req & PRIO_BIT)) && ((prio_cnt < 4'(PRIO_MAX)) || !others_req);

   always_comb begin
      rr_hit = 1'b0;
      rr_ch  = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (!rr_hit && wrap(int'(rr_ptr) + k) != PRIO_CH &&
             (|(req & onehot(wrap(int'(rr_ptr) + k))))) begin
            rr_hit = 1'b1;
            rr_ch  = wrap(int'(rr_ptr) + k);
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (prio_ok)
         gnt = PRIO_BIT;
      else if (rr_hit)
         gnt = onehot(rr_ch);
      sel_addr  = '0;
      sel_wdata = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (gnt[c]) begin
            sel_addr  = sel_addr  | addr[c*ADDRWIDTH +: ADDRWIDTH];
            sel_wdata = sel_wdata | wdata[c*DATAWIDTH +: DATAWIDTH];
         end
      end
   end

   assign xfer      = |gnt;
   assign xfer_prio = |(gnt & PRIO_BIT);
   assign sel_we    = |(gnt & we);
   assign rr_next   = PTRW'(next_ch(rr_ch));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr   <= '0;
         prio_cnt <= '0;
         mem_en   <= 1'b0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
         rvalid   <= '0;
         rdata    <= '0;
         for (int d = 0; d < DEPTH; d++) tag_pipe[d] <= '0;
      end else begin
         if (!others_req)
            prio_cnt <= '0;
         else if (xfer_prio) begin
            if (prio_cnt < 4'(PRIO_MAX)) prio_cnt <= prio_cnt + 4'd1;
         end else if (xfer)
            prio_cnt <= '0;

         if (xfer && !xfer_prio) rr_ptr <= rr_next;

         mem_en <= xfer;
         mem_we <= xfer & sel_we;
         if (xfer) begin
            mem_addr <= sel_addr;
            mem_din  <= sel_wdata;
         end

         // Writes push an empty tag so read order and spacing stay fixed.
         tag_pipe[0] <= (xfer && !sel_we) ? gnt : '0;
         for (int d = 1; d < DEPTH; d++) tag_pipe[d] <= tag_pipe[d-1];
         rvalid <= tag_pipe[DEPTH-1];
         if (|tag_pipe[DEPTH-1]) rdata <= mem_dout;
      end
   end

endmodule
